uart_rx_ctrl: RTL and testbench

Receive-side controller for the CPU's UART peripheral. It sits between the UART receiver (byte + status output) and the CPU data bus. It detects each completed byte, queues it in a small FIFO so back-to-back frames are not lost while the CPU is busy, and exposes memory-mapped data and control/status registers. It also raises a level interrupt request to the CPU interrupt logic while data is pending and interrupts are enabled.

---
 rtl/uart_rx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller: edge-detected byte capture into a
//               small FIFO, memory-mapped RXD/CON registers and level irq.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ADDR_RXD = 32'h4000001C,
    parameter logic [31:0] ADDR_CON = 32'h40000020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_status,
    input  logic [7:0]  rx_data,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [7:0]         r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_rx_status_d;
    logic               r_overrun;
    logic               r_int_en;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_rd_rxd;
    logic               w_rd_con;
    logic               w_wr_con;
    logic               w_pop;
    logic               w_accept;
    logic               w_overrun_evt;
    logic [4:0]         w_count_ext;
    logic [2:0]         w_count_sat;
    logic               w_unused;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_FULL);
    assign w_push        = rx_status & ~r_rx_status_d;
    assign w_rd_rxd      = rd & (addr == ADDR_RXD);
    assign w_rd_con      = rd & (addr == ADDR_CON);
    assign w_wr_con      = wr & (addr == ADDR_CON);
    assign w_pop         = w_rd_rxd & ~w_empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_accept      = w_push & (~w_full | w_pop);
    assign w_overrun_evt = w_push & w_full & ~w_pop;
    assign w_count_ext   = 5'(r_count);
    assign w_count_sat   = (w_count_ext > 5'd7) ? 3'd7 : w_count_ext[2:0];
    assign w_unused      = ^{wdata[31:3], wdata[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overrun     <= 1'b0;
            r_int_en      <= 1'b0;
            r_rx_status_d <= 1'b1;
        end else begin
            r_rx_status_d <= rx_status;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_con) begin
                r_int_en <= wdata[0];
            end
            // A new overrun outranks a simultaneous write-1-to-clear.
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (w_wr_con && wdata[2]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_fifo[r_wr_ptr] <= rx_data;
        end
    end

    always_comb begin
        rdata = 32'b0;
        if (w_rd_rxd && !w_empty) begin
            rdata = {24'b0, r_fifo[r_rd_ptr]};
        end else if (w_rd_con) begin
            rdata = {26'b0, w_count_sat, r_overrun, ~w_empty, r_int_en};
        end
    end

    assign irq = r_int_en & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed scenarios plus randomized traffic for uart_rx_ctrl,
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] A_RXD   = 32'h4000001C;
    localparam logic [31:0] A_CON   = 32'h40000020;
    localparam logic [31:0] A_OTHER = 32'h40000024;

    logic        clk;
    logic        reset;
    logic        rx_status;
    logic [7:0]  rx_data;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    uart_rx_ctrl #(
        .DEPTH    (DEPTH),
        .ADDR_RXD (A_RXD),
        .ADDR_CON (A_CON)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_status (rx_status),
        .rx_data   (rx_data),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rdata;
    logic        st_q;
    logic [7:0]  d_q;

    // Reference model: byte queue plus flags.
    logic [7:0]  mq[$];
    logic        m_ovr;
    logic        m_ien;
    logic        m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
        int n;
        n = mq.size();
        if (r && a == A_RXD) return (n > 0) ? {24'b0, mq[0]} : 32'b0;
        if (r && a == A_CON) begin
            int c;
            logic [2:0] c3;
            c  = (n > 7) ? 7 : n;
            c3 = 3'(c);
            return {26'b0, c3, m_ovr, (n != 0), m_ien};
        end
        return 32'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_ien  = 1'b0;
        m_prev = 1'b1;
    endtask

    task automatic step(input logic st, input logic [7:0] d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd, input logic rs);
        logic push;
        logic ovr_evt;
        @(negedge clk);
        rx_status = st;
        rx_data   = d;
        rd        = r;
        wr        = w;
        addr      = a;
        wdata     = wd;
        reset     = rs;
        #1;
        check("rdata", rdata, model_rdata(r, a));
        check("irq", {31'b0, irq}, {31'b0, m_ien && (mq.size() != 0)});
        last_rdata = rdata;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            push    = st && !m_prev;
            ovr_evt = 1'b0;
            if (r && a == A_RXD && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else                   ovr_evt = 1'b1;
            end
            if (w && a == A_CON) begin
                m_ien = wd[0];
                if (wd[2]) m_ovr = 1'b0;
            end
            if (ovr_evt) m_ovr = 1'b1;
            m_prev = st;
        end
    endtask

    task automatic idle();
        step(st_q, d_q, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rd_rxd();
        step(st_q, d_q, 1'b1, 1'b0, A_RXD, 32'h0, 1'b0);
    endtask

    task automatic rd_con();
        step(st_q, d_q, 1'b1, 1'b0, A_CON, 32'h0, 1'b0);
    endtask

    task automatic wr_con(input logic [31:0] v);
        step(st_q, d_q, 1'b0, 1'b1, A_CON, v, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        st_q = 1'b1;
        d_q  = b;
        idle();
        st_q = 1'b0;
        idle();
    endtask

    task automatic expect_rxd(input string tag, input logic [7:0] b);
        rd_rxd();
        check(tag, last_rdata, {24'b0, b});
    endtask

    task automatic expect_con(input string tag, input logic [31:0] v);
        rd_con();
        check(tag, last_rdata, v);
    endtask

    initial begin
        int hold;
        logic [7:0] seq [6];
        reset = 1'b1; rx_status = 1'b0; rx_data = 8'h00;
        addr = 32'h0; rd = 1'b0; wr = 1'b0; wdata = 32'h0;
        st_q = 1'b0; d_q = 8'h00;
        repeat (2) @(posedge clk);
        model_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_con("reset_con", 32'h0);
        expect_rxd("reset_rxd", 8'h00);

        // Single byte held for many cycles.
        wr_con(32'h1);
        st_q = 1'b1; d_q = 8'hA5;
        repeat (200) idle();
        st_q = 1'b0;
        expect_con("single_con", 32'h0B);
        expect_rxd("single_rxd", 8'hA5);
        expect_con("single_con_after", 32'h01);

        // Order and pointer wrap.
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 0; i < 3; i++) push_byte(seq[i]);
        for (int i = 0; i < 2; i++) expect_rxd("order", seq[i]);
        for (int i = 3; i < 6; i++) push_byte(seq[i]);
        for (int i = 2; i < 6; i++) expect_rxd("order", seq[i]);

        // Overrun.
        wr_con(32'h0);
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        expect_con("ovr_con", 32'h26);
        for (int i = 0; i < 4; i++) expect_rxd("ovr_rxd", 8'h10 + 8'(i));
        wr_con(32'h4);
        expect_con("ovr_cleared", 32'h0);

        // Full FIFO: push and pop in the same cycle.
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        step(1'b1, 8'h24, 1'b1, 1'b0, A_RXD, 32'h0, 1'b0);
        check("full_pushpop_rd", last_rdata, 32'h20);
        st_q = 1'b0;
        expect_con("full_pushpop_con", 32'h22);
        for (int i = 1; i < 5; i++) expect_rxd("full_pushpop_order", 8'h20 + 8'(i));

        // Empty FIFO: push and RXD read in the same cycle.
        step(1'b1, 8'h30, 1'b1, 1'b0, A_RXD, 32'h0, 1'b0);
        check("empty_pushpop_rd", last_rdata, 32'h0);
        st_q = 1'b0;
        expect_con("empty_pushpop_con", 32'h0A);

        // Overrun coinciding with a clear.
        for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
        step(1'b1, 8'h43, 1'b0, 1'b1, A_CON, 32'h4, 1'b0);
        st_q = 1'b0;
        expect_con("ovr_vs_clear", 32'h26);

        // Reset mid-operation while rx_status is high.
        expect_rxd("pre_reset_rxd", 8'h30);
        wr_con(32'h1);
        expect_con("pre_reset_con", 32'h1F);
        step(1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        st_q = 1'b1; d_q = 8'h55;
        repeat (3) idle();
        expect_con("post_reset_con", 32'h0);
        check("post_reset_irq", {31'b0, irq}, 32'h0);
        st_q = 1'b0;
        idle();
        push_byte(8'h66);
        expect_con("post_reset_push", 32'h0A);
        expect_rxd("post_reset_rxd", 8'h66);

        // Randomized traffic.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        w;
            logic [31:0] a;
            logic        rs;
            if (hold == 0) begin
                st_q = ~st_q;
                hold = $urandom_range(1, 6);
                if (st_q) d_q = 8'($urandom);
            end
            hold--;
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0, 1:    a = A_RXD;
                2:       a = A_CON;
                default: a = A_OTHER;
            endcase
            rs = ($urandom_range(0, 199) == 0);
            step(st_q, d_q, r, w, a, $urandom, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
